ip_io_bus_switch: RTL and testbench

Parametrised I/O-bus fabric between `msx_slot` and NUM_PORTS I/O peripherals (VDP, GPIO, future PSG/OPLL, …), replacing hand-written per-device `ioreq` decode and `rdata` muxing in the top level. It matches the Z80 I/O address against per-port base/mask pairs and forwards one transaction at a time to the selected port. It routes read data back, answers unmapped reads with 0xFF, and aborts hung transactions after a timeout.

---
 rtl/ip_io_bus_switch_pkg.sv | 23 ++
 rtl/ip_io_bus_switch_if.sv | 39 +++
 rtl/ip_io_addr_match.sv | 30 +++
 rtl/ip_io_bus_switch.sv | 169 ++++++++++++++++
 tb/tb_ip_io_bus_switch.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/ip_io_bus_switch_pkg.sv
// Shared types and constants for the I/O bus switch: FSM encoding, bus widths
// and the value returned for reads nobody answers.
package ip_io_bus_switch_pkg;

    localparam int BUS_DATA_W = 8;
    localparam int BUS_ADDR_W = 8;
    localparam int TIMEOUT_W  = 8;
    localparam int PORT_IDX_W = 3;

    localparam logic [BUS_DATA_W-1:0] UNMAPPED_DATA = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT_RD = 2'd2,
        ST_RESP    = 2'd3
    } state_t;

    function automatic logic [TIMEOUT_W-1:0] sat_inc(input logic [TIMEOUT_W-1:0] value);
        return (value == '1) ? value : value + TIMEOUT_W'(1);
    endfunction

endpackage

// File: rtl/ip_io_bus_switch_if.sv
// Upstream Z80 I/O bus plus the shared downstream device bus. The switch uses
// the slave view; the slot/devices side (or a bench) uses the master view.
interface ip_io_bus_switch_if #(
    parameter int NUM_PORTS = 4
);
    import ip_io_bus_switch_pkg::*;

    logic [BUS_ADDR_W-1:0]           bus_address;
    logic                            bus_ioreq;
    logic                            bus_write;
    logic                            bus_valid;
    logic                            bus_ready;
    logic [BUS_DATA_W-1:0]           bus_wdata;
    logic [BUS_DATA_W-1:0]           bus_rdata;
    logic                            bus_rdata_en;

    logic [BUS_ADDR_W-1:0]           dev_address;
    logic                            dev_write;
    logic [BUS_DATA_W-1:0]           dev_wdata;
    logic [NUM_PORTS-1:0]            dev_valid;
    logic [NUM_PORTS-1:0]            dev_ready;
    logic [NUM_PORTS*BUS_DATA_W-1:0] dev_rdata;
    logic [NUM_PORTS-1:0]            dev_rdata_en;

    modport slave (
        input  bus_address, bus_ioreq, bus_write, bus_valid, bus_wdata,
        input  dev_ready, dev_rdata, dev_rdata_en,
        output bus_ready, bus_rdata, bus_rdata_en,
        output dev_address, dev_write, dev_wdata, dev_valid
    );

    modport master (
        output bus_address, bus_ioreq, bus_write, bus_valid, bus_wdata,
        output dev_ready, dev_rdata, dev_rdata_en,
        input  bus_ready, bus_rdata, bus_rdata_en,
        input  dev_address, dev_write, dev_wdata, dev_valid
    );

endinterface

// File: rtl/ip_io_addr_match.sv
// Combinational address decoder: reports whether any enabled port claims the
// address and, if several do, the index of the lowest one.
module ip_io_addr_match
    import ip_io_bus_switch_pkg::*;
#(
    parameter int                         NUM_PORTS = 4,
    parameter logic [NUM_PORTS*8-1:0]     PORT_BASE = {8'h98, 8'h88, 8'h10, 8'h00},
    parameter logic [NUM_PORTS*8-1:0]     PORT_MASK = {8'hFC, 8'hFC, 8'hFC, 8'h00},
    parameter logic [NUM_PORTS-1:0]       PORT_EN   = 4'b0111
) (
    input  logic [BUS_ADDR_W-1:0] i_address,
    output logic                  o_hit,
    output logic [PORT_IDX_W-1:0] o_index
);

    // Walk from the highest port down so the lowest matching index is the last write.
    always_comb begin
        o_hit   = 1'b0;
        o_index = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (PORT_EN[k] &&
                ((i_address & PORT_MASK[BUS_ADDR_W*k +: BUS_ADDR_W]) ==
                 (PORT_BASE[BUS_ADDR_W*k +: BUS_ADDR_W] & PORT_MASK[BUS_ADDR_W*k +: BUS_ADDR_W]))) begin
                o_hit   = 1'b1;
                o_index = PORT_IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/ip_io_bus_switch.sv
// I/O bus fabric: decodes Z80 I/O addresses onto NUM_PORTS peripherals, one
// transaction at a time, with 0xFF for unmapped reads and a stall timeout.
module ip_io_bus_switch
    import ip_io_bus_switch_pkg::*;
#(
    parameter int                         NUM_PORTS = 4,
    parameter logic [NUM_PORTS*8-1:0]     PORT_BASE = {8'h98, 8'h88, 8'h10, 8'h00},
    parameter logic [NUM_PORTS*8-1:0]     PORT_MASK = {8'hFC, 8'hFC, 8'hFC, 8'h00},
    parameter logic [NUM_PORTS-1:0]       PORT_EN   = 4'b0111,
    parameter int                         TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 reset_n,
    ip_io_bus_switch_if.slave    io_bus,
    output logic [TIMEOUT_W-1:0] timeout_count
);

    localparam logic [TIMEOUT_W-1:0] TIMEOUT_L = TIMEOUT_W'(TIMEOUT);

    state_t                  r_state;
    logic [BUS_ADDR_W-1:0]   r_addr;
    logic                    r_write;
    logic [BUS_DATA_W-1:0]   r_wdata;
    logic [PORT_IDX_W-1:0]   r_port;
    logic [NUM_PORTS-1:0]    r_dev_valid;
    logic                    r_ready;
    logic [BUS_DATA_W-1:0]   r_rdata;
    logic                    r_rdata_en;
    logic [TIMEOUT_W-1:0]    r_timer;
    logic [TIMEOUT_W-1:0]    r_timeout_count;

    logic                    w_hit;
    logic                    w_mapped;
    logic [PORT_IDX_W-1:0]   w_index;
    logic [NUM_PORTS-1:0]    w_onehot;
    logic                    w_sel_ready;
    logic                    w_sel_strobe;
    logic [BUS_DATA_W-1:0]   w_sel_rdata;
    logic                    w_expired;

    ip_io_addr_match #(
        .NUM_PORTS (NUM_PORTS),
        .PORT_BASE (PORT_BASE),
        .PORT_MASK (PORT_MASK),
        .PORT_EN   (PORT_EN)
    ) u_addr_match (
        .i_address (io_bus.bus_address),
        .o_hit     (w_hit),
        .o_index   (w_index)
    );

    // Memory cycles never reach a peripheral, whatever the address decodes to.
    assign w_mapped  = w_hit & io_bus.bus_ioreq;
    assign w_expired = (r_timer == TIMEOUT_L);

    always_comb begin
        w_onehot     = '0;
        w_sel_ready  = 1'b0;
        w_sel_strobe = 1'b0;
        w_sel_rdata  = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            w_onehot[k] = (w_index == PORT_IDX_W'(k));
            if (r_port == PORT_IDX_W'(k)) begin
                w_sel_ready  = io_bus.dev_ready[k];
                w_sel_strobe = io_bus.dev_rdata_en[k];
                w_sel_rdata  = io_bus.dev_rdata[BUS_DATA_W*k +: BUS_DATA_W];
            end
        end
    end

    // Device responses are tested before the timeout so a same-cycle reply is never aborted.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state         <= ST_IDLE;
            r_addr          <= '0;
            r_write         <= 1'b0;
            r_wdata         <= '0;
            r_port          <= '0;
            r_dev_valid     <= '0;
            r_ready         <= 1'b1;
            r_rdata         <= UNMAPPED_DATA;
            r_rdata_en      <= 1'b0;
            r_timer         <= '0;
            r_timeout_count <= '0;
        end else begin
            r_rdata_en <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (io_bus.bus_valid) begin
                        r_addr  <= io_bus.bus_address;
                        r_write <= io_bus.bus_write;
                        r_wdata <= io_bus.bus_wdata;
                        r_port  <= w_index;
                        r_timer <= '0;
                        if (w_mapped) begin
                            r_state     <= ST_ISSUE;
                            r_dev_valid <= w_onehot;
                            r_ready     <= 1'b0;
                        end else if (!io_bus.bus_write) begin
                            r_state    <= ST_RESP;
                            r_rdata    <= UNMAPPED_DATA;
                            r_rdata_en <= 1'b1;
                            r_ready    <= 1'b0;
                        end
                    end
                end
                ST_ISSUE: begin
                    r_timer <= r_timer + TIMEOUT_W'(1);
                    if (w_sel_ready) begin
                        r_dev_valid <= '0;
                        if (r_write) begin
                            r_state <= ST_IDLE;
                            r_ready <= 1'b1;
                        end else if (w_sel_strobe) begin
                            r_state    <= ST_RESP;
                            r_rdata    <= w_sel_rdata;
                            r_rdata_en <= 1'b1;
                        end else begin
                            r_state <= ST_WAIT_RD;
                        end
                    end else if (w_expired) begin
                        r_dev_valid     <= '0;
                        r_timeout_count <= sat_inc(r_timeout_count);
                        if (r_write) begin
                            r_state <= ST_IDLE;
                            r_ready <= 1'b1;
                        end else begin
                            r_state    <= ST_RESP;
                            r_rdata    <= UNMAPPED_DATA;
                            r_rdata_en <= 1'b1;
                        end
                    end
                end
                ST_WAIT_RD: begin
                    r_timer <= r_timer + TIMEOUT_W'(1);
                    if (w_sel_strobe) begin
                        r_state    <= ST_RESP;
                        r_rdata    <= w_sel_rdata;
                        r_rdata_en <= 1'b1;
                    end else if (w_expired) begin
                        r_state         <= ST_RESP;
                        r_rdata         <= UNMAPPED_DATA;
                        r_rdata_en      <= 1'b1;
                        r_timeout_count <= sat_inc(r_timeout_count);
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_ready     <= 1'b1;
                    r_dev_valid <= '0;
                end
            endcase
        end
    end

    assign io_bus.bus_ready    = r_ready;
    assign io_bus.bus_rdata    = r_rdata;
    assign io_bus.bus_rdata_en = r_rdata_en;
    assign io_bus.dev_address  = r_addr;
    assign io_bus.dev_write    = r_write;
    assign io_bus.dev_wdata    = r_wdata;
    assign io_bus.dev_valid    = r_dev_valid;
    assign timeout_count       = r_timeout_count;

endmodule

// File: tb/tb_ip_io_bus_switch.sv
// Bench for ip_io_bus_switch: a table of single transactions against one
// instance, plus hand sequences for priority, stray strobes, saturation, reset.
module tb_ip_io_bus_switch;
    import ip_io_bus_switch_pkg::*;

    typedef struct {
        string      name;
        logic       wr;
        logic       io;
        logic [7:0] addr;
        logic [7:0] wdata;
        int         ack;
        int         rd;
        logic [7:0] data;
        logic [3:0] expValid;
        int         expVCyc;
        int         expRdEn;
        logic [7:0] expRdata;
        int         expReady;
        int         toInc;
    } vec_t;

    typedef struct {
        logic [3:0] validOr;
        int         validCycles;
        int         rdEnCycle;
        logic [7:0] rdata;
        int         readyCycle;
        logic [7:0] devAddr;
        logic [7:0] devWdata;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] toCountA;
    logic [7:0] toCountB;
    int         errors = 0;
    int         checks = 0;
    int         expTo = 0;
    vec_t       vecs[16];
    obs_t       o;

    always #5 clk = ~clk;

    ip_io_bus_switch_if #(.NUM_PORTS(4)) busA();
    ip_io_bus_switch_if #(.NUM_PORTS(4)) busB();

    // A: port0=0x98, port1=0x88, port2=0x10, port3 disabled
    ip_io_bus_switch #(
        .NUM_PORTS(4), .PORT_BASE(32'h0010_8898), .PORT_MASK(32'h00FC_FCFC),
        .PORT_EN(4'b0111), .TIMEOUT(8)
    ) dutA (.clk(clk), .reset_n(reset_n), .io_bus(busA), .timeout_count(toCountA));

    // B: port0 and port2 both at 0x10, shadowing A's inputs
    ip_io_bus_switch #(
        .NUM_PORTS(4), .PORT_BASE(32'h0010_8810), .PORT_MASK(32'h00FC_FCFC),
        .PORT_EN(4'b0111), .TIMEOUT(8)
    ) dutB (.clk(clk), .reset_n(reset_n), .io_bus(busB), .timeout_count(toCountB));

    assign busB.bus_address  = busA.bus_address;
    assign busB.bus_ioreq    = busA.bus_ioreq;
    assign busB.bus_write    = busA.bus_write;
    assign busB.bus_valid    = busA.bus_valid;
    assign busB.bus_wdata    = busA.bus_wdata;
    assign busB.dev_ready    = busA.dev_ready;
    assign busB.dev_rdata    = busA.dev_rdata;
    assign busB.dev_rdata_en = busA.dev_rdata_en;

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Starts at a negedge with the switch idle; ends at the negedge where bus_ready is back.
    task automatic applyStimulus(input vec_t v, output obs_t ob);
        ob.validOr = 0; ob.validCycles = 0; ob.rdEnCycle = 0; ob.rdata = 0;
        ob.readyCycle = 0; ob.devAddr = 0; ob.devWdata = 0;
        busA.bus_address = v.addr;
        busA.bus_write   = v.wr;
        busA.bus_wdata   = v.wdata;
        busA.bus_ioreq   = v.io;
        busA.bus_valid   = 1'b1;
        busA.dev_rdata   = {4{v.data}};
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            busA.bus_valid = 1'b0;
            if (busA.dev_valid != 4'h0) begin
                ob.validOr     = ob.validOr | busA.dev_valid;
                ob.validCycles = ob.validCycles + 1;
                ob.devAddr     = busA.dev_address;
                ob.devWdata    = busA.dev_wdata;
            end
            if (busA.bus_rdata_en) begin
                ob.rdEnCycle = c;
                ob.rdata     = busA.bus_rdata;
            end
            if (busA.bus_ready) begin
                ob.readyCycle = c;
                break;
            end
            busA.dev_ready    = (v.ack >= 0 && c == 1 + v.ack) ? 4'hF : 4'h0;
            busA.dev_rdata_en = (v.ack >= 0 && v.rd >= 0 && c == 1 + v.ack + v.rd) ? 4'hF : 4'h0;
        end
        busA.dev_ready    = 4'h0;
        busA.dev_rdata_en = 4'h0;
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got no completion, expected finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        //            name        wr    io    addr   wdata  ack rd  data   valid  vc  rdEn rdata  rdy to
        vecs[0]  = '{"rd99",      1'b0, 1'b1, 8'h99, 8'h00,  0,  1, 8'h5A, 4'h1, 1,  3, 8'h5A,  4, 0};
        vecs[1]  = '{"wr88stall", 1'b1, 1'b1, 8'h88, 8'h3C,  4, -1, 8'h00, 4'h2, 5,  0, 8'h00,  6, 0};
        vecs[2]  = '{"rd40unmap", 1'b0, 1'b1, 8'h40, 8'h00, -1, -1, 8'h00, 4'h0, 0,  1, 8'hFF,  2, 0};
        vecs[3]  = '{"rdMem",     1'b0, 1'b0, 8'h99, 8'h00,  0,  1, 8'h77, 4'h0, 0,  1, 8'hFF,  2, 0};
        vecs[4]  = '{"wr40drop",  1'b1, 1'b1, 8'h40, 8'h55, -1, -1, 8'h00, 4'h0, 0,  0, 8'h00,  1, 0};
        vecs[5]  = '{"rd9B",      1'b0, 1'b1, 8'h9B, 8'h00,  0,  1, 8'hA5, 4'h1, 1,  3, 8'hA5,  4, 0};
        vecs[6]  = '{"rd9Cunmap", 1'b0, 1'b1, 8'h9C, 8'h00,  0,  1, 8'h12, 4'h0, 0,  1, 8'hFF,  2, 0};
        vecs[7]  = '{"rd00dis",   1'b0, 1'b1, 8'h00, 8'h00,  0,  1, 8'h34, 4'h0, 0,  1, 8'hFF,  2, 0};
        vecs[8]  = '{"rdSame",    1'b0, 1'b1, 8'h8A, 8'h00,  0,  0, 8'hC3, 4'h2, 1,  2, 8'hC3,  3, 0};
        vecs[9]  = '{"rdSlow",    1'b0, 1'b1, 8'h8B, 8'h00,  2,  3, 8'h3E, 4'h2, 3,  7, 8'h3E,  8, 0};
        vecs[10] = '{"wr13",      1'b1, 1'b1, 8'h13, 8'hE7,  1, -1, 8'h00, 4'h4, 2,  0, 8'h00,  3, 0};
        vecs[11] = '{"rdToIssue", 1'b0, 1'b1, 8'h12, 8'h00, -1, -1, 8'h00, 4'h4, 9, 10, 8'hFF, 11, 1};
        vecs[12] = '{"wrTo",      1'b1, 1'b1, 8'h10, 8'h99, -1, -1, 8'h00, 4'h4, 9,  0, 8'h00, 10, 1};
        vecs[13] = '{"rdToWait",  1'b0, 1'b1, 8'h11, 8'h00,  0, -1, 8'h00, 4'h4, 1, 10, 8'hFF, 11, 1};
        vecs[14] = '{"wrTie",     1'b1, 1'b1, 8'h99, 8'h11,  8, -1, 8'h00, 4'h1, 9,  0, 8'h00, 10, 0};
        vecs[15] = '{"rdTie",     1'b0, 1'b1, 8'h98, 8'h00,  0,  8, 8'h6D, 4'h1, 1, 10, 8'h6D, 11, 0};

        busA.bus_address = 0; busA.bus_ioreq = 0; busA.bus_write = 0; busA.bus_valid = 0;
        busA.bus_wdata = 0; busA.dev_ready = 0; busA.dev_rdata = 0; busA.dev_rdata_en = 0;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst.ready",   busA.bus_ready, 1);
        checkOutput("rst.rdata",   busA.bus_rdata, 8'hFF);
        checkOutput("rst.rdataEn", busA.bus_rdata_en, 0);
        checkOutput("rst.devValid", busA.dev_valid, 0);
        checkOutput("rst.devAddr", busA.dev_address, 0);
        checkOutput("rst.devWrite", busA.dev_write, 0);
        checkOutput("rst.devWdata", busA.dev_wdata, 0);
        checkOutput("rst.toCount", toCountA, 0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i], o);
            expTo = (expTo + vecs[i].toInc > 255) ? 255 : expTo + vecs[i].toInc;
            checkOutput($sformatf("%s.validOr", vecs[i].name), o.validOr, vecs[i].expValid);
            checkOutput($sformatf("%s.validCyc", vecs[i].name), o.validCycles, vecs[i].expVCyc);
            checkOutput($sformatf("%s.rdEnCyc", vecs[i].name), o.rdEnCycle, vecs[i].expRdEn);
            checkOutput($sformatf("%s.readyCyc", vecs[i].name), o.readyCycle, vecs[i].expReady);
            checkOutput($sformatf("%s.toCount", vecs[i].name), toCountA, expTo);
            if (vecs[i].expRdEn != 0)
                checkOutput($sformatf("%s.rdata", vecs[i].name), o.rdata, vecs[i].expRdata);
            if (vecs[i].expValid != 4'h0)
                checkOutput($sformatf("%s.devAddr", vecs[i].name), o.devAddr, vecs[i].addr);
            if (vecs[i].wr && vecs[i].expValid != 4'h0)
                checkOutput($sformatf("%s.devWdata", vecs[i].name), o.devWdata, vecs[i].wdata);
        end

        // Overlapping bases: B has ports 0 and 2 at 0x10, A only port 2
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        busA.bus_address = 8'h11; busA.bus_write = 1'b0; busA.bus_ioreq = 1'b1; busA.bus_valid = 1'b1;
        @(negedge clk);
        busA.bus_valid = 1'b0;
        checkOutput("ovl.validA", busA.dev_valid, 4'b0100);
        checkOutput("ovl.validB", busB.dev_valid, 4'b0001);
        busA.dev_rdata = 32'h4433_2211; busA.dev_ready = 4'hF; busA.dev_rdata_en = 4'hF;
        @(negedge clk);
        busA.dev_ready = 4'h0; busA.dev_rdata_en = 4'h0;
        checkOutput("ovl.rdEnA", busA.bus_rdata_en, 1);
        checkOutput("ovl.rdataA", busA.bus_rdata, 8'h33);
        checkOutput("ovl.rdEnB", busB.bus_rdata_en, 1);
        checkOutput("ovl.rdataB", busB.bus_rdata, 8'h11);
        @(negedge clk);
        checkOutput("ovl.readyA", busA.bus_ready, 1);

        // A strobe on a non-selected port must not complete the read
        busA.bus_address = 8'h9A; busA.bus_valid = 1'b1;
        @(negedge clk);
        busA.bus_valid = 1'b0; busA.dev_ready = 4'hF;
        @(negedge clk);
        busA.dev_ready = 4'h0; busA.dev_rdata_en = 4'b0010;
        @(negedge clk);
        checkOutput("ign.noRdEn", busA.bus_rdata_en, 0);
        busA.dev_rdata_en = 4'b0001;
        @(negedge clk);
        busA.dev_rdata_en = 4'h0;
        checkOutput("ign.rdEn", busA.bus_rdata_en, 1);
        checkOutput("ign.rdata", busA.bus_rdata, 8'h11);
        @(negedge clk);

        // 300 aborted reads saturate the counter
        for (int n = 0; n < 300; n++) applyStimulus(vecs[11], o);
        checkOutput("sat.toCount", toCountA, 255);

        // Reset while waiting for read data; the late strobe must be ignored
        applyStimulus(vecs[0], o);
        checkOutput("mid.preRdata", o.rdata, 8'h5A);
        busA.bus_address = 8'h99; busA.bus_write = 1'b0; busA.bus_ioreq = 1'b1; busA.bus_valid = 1'b1;
        @(negedge clk);
        busA.bus_valid = 1'b0; busA.dev_ready = 4'hF;
        @(negedge clk);
        busA.dev_ready = 4'h0; reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1; busA.dev_rdata_en = 4'hF; busA.dev_rdata = 32'h4433_2211;
        checkOutput("mid.ready", busA.bus_ready, 1);
        checkOutput("mid.rdEn", busA.bus_rdata_en, 0);
        checkOutput("mid.rdata", busA.bus_rdata, 8'hFF);
        checkOutput("mid.devValid", busA.dev_valid, 0);
        checkOutput("mid.devAddr", busA.dev_address, 0);
        checkOutput("mid.toCount", toCountA, 0);
        @(negedge clk);
        busA.dev_rdata_en = 4'h0;
        checkOutput("mid.lateRdEn", busA.bus_rdata_en, 0);
        checkOutput("mid.lateReady", busA.bus_ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
